// File: rtl/if_branch_prediction_bht_pkg.sv
// Shared helpers for the bimodal/gshare branch history table: counter update and index hash.
package bp_pkg;

  localparam int CNT_BITS_DEF = 2;

  // Saturating step of a counter up to 4 bits wide; cnt_bits selects the ceiling.
  function automatic logic [3:0] sat_update(input logic [3:0] cnt, input logic take, input int cnt_bits);
    logic [3:0] top;
    top = 4'((5'd1 << cnt_bits) - 5'd1);
    if (take) begin
      if (cnt == top) sat_update = cnt;
      else            sat_update = cnt + 4'd1;
    end else begin
      if (cnt == 4'd0) sat_update = cnt;
      else             sat_update = cnt - 4'd1;
    end
  endfunction

  function automatic logic [15:0] bp_index(input logic [31:0] pc, input logic [15:0] ghr,
                                           input int pc_lsb, input int index_bits);
    logic [31:0] mask;
    logic [31:0] raw;
    mask = (32'd1 << index_bits) - 32'd1;
    raw  = ((pc >> pc_lsb) ^ {16'd0, ghr}) & mask;
    bp_index = raw[15:0];
  endfunction

endpackage

// File: rtl/if_branch_prediction_bht_table.sv
// Register array of saturating counters: one write port, two combinational read ports.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = CNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic [CNT_BITS-1:0]   wdata,
  input  logic [INDEX_BITS-1:0] raddr_a,
  output logic [CNT_BITS-1:0]   rdata_a,
  input  logic [INDEX_BITS-1:0] raddr_b,
  output logic [CNT_BITS-1:0]   rdata_b
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] INIT = CNT_BITS'(1) << (CNT_BITS - 1);

  logic [CNT_BITS-1:0] mem [ENTRIES];

  // Counter storage; reset parks every entry at weakly-taken and beats any write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= INIT;
    end else if (we) begin
      mem[waddr] <= wdata;
    end else begin
      mem[waddr] <= mem[waddr];
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/if_branch_prediction_bht.sv
// IF-stage dynamic branch predictor (saturating-counter BHT); define GSHARE_EN to hash the index with global history.
module if_branch_prediction_bht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = CNT_BITS_DEF,
  parameter int PC_LSB     = 2,
  parameter int HIST_BITS  = 6,
  parameter int PERF_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_query,
  input  logic                 pc_jmp_feedback,
  input  logic                 pc_jmp_take,
  input  logic [31:0]          pc_stash_base,
  input  logic [31:0]          pc_jmp,
  output logic                 pc_prediction_take,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts,
  output logic [31:0]          last_target
);

  logic [15:0]           hist_s;
  logic [INDEX_BITS-1:0] q_idx_s;
  logic [INDEX_BITS-1:0] u_idx_s;
  logic [CNT_BITS-1:0]   q_cnt_s;
  logic [CNT_BITS-1:0]   u_cnt_s;
  logic [CNT_BITS-1:0]   u_next_s;
  logic                  mispredict_s;

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] ghr;

  // Global history shifts in each resolved outcome; both indices see the pre-shift value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr <= {HIST_BITS{1'b0}};
    end else if (pc_jmp_feedback) begin
      ghr <= HIST_BITS'({ghr, pc_jmp_take});
    end else begin
      ghr <= ghr;
    end
  end

  assign hist_s = 16'(ghr);
`else
  logic [HIST_BITS-1:0] ghr_zero_s;
  assign ghr_zero_s = {HIST_BITS{1'b0}};
  assign hist_s     = 16'(ghr_zero_s);
`endif

  assign q_idx_s      = INDEX_BITS'(bp_index(pc_query, hist_s, PC_LSB, INDEX_BITS));
  assign u_idx_s      = INDEX_BITS'(bp_index(pc_stash_base, hist_s, PC_LSB, INDEX_BITS));
  assign u_next_s     = CNT_BITS'(sat_update(4'(u_cnt_s), pc_jmp_take, CNT_BITS));
  assign mispredict_s = (u_cnt_s[CNT_BITS-1] != pc_jmp_take);

  bp_sat_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CNT_BITS   (CNT_BITS)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (pc_jmp_feedback),
    .waddr   (u_idx_s),
    .wdata   (u_next_s),
    .raddr_a (q_idx_s),
    .rdata_a (q_cnt_s),
    .raddr_b (u_idx_s),
    .rdata_b (u_cnt_s)
  );

  // Legacy always-taken answer while reset is held.
  assign pc_prediction_take = reset ? q_cnt_s[CNT_BITS-1] : 1'b1;

  // Perf counters wrap freely; last_target is a debug capture only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_branches    <= {PERF_BITS{1'b0}};
      perf_mispredicts <= {PERF_BITS{1'b0}};
      last_target      <= 32'd0;
    end else if (pc_jmp_feedback) begin
      perf_branches    <= perf_branches + PERF_BITS'(1);
      perf_mispredicts <= mispredict_s ? perf_mispredicts + PERF_BITS'(1) : perf_mispredicts;
      last_target      <= pc_jmp;
    end else begin
      perf_branches    <= perf_branches;
      perf_mispredicts <= perf_mispredicts;
      last_target      <= last_target;
    end
  end

endmodule

// File: tb/tb_if_branch_prediction_bht.sv
// Self-checking bench for if_branch_prediction_bht: directed vector table, corner sequences, randomized model check.
module tb_if_branch_prediction_bht;

  logic        clk;
  logic        reset;
  logic [31:0] pc_query;
  logic        pc_jmp_feedback;
  logic        pc_jmp_take;
  logic [31:0] pc_stash_base;
  logic [31:0] pc_jmp;
  logic        pc_prediction_take;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  logic [31:0] last_target;

  int vectors;
  int miscompares;

  if_branch_prediction_bht u_dut (
    .clk                (clk),
    .reset              (reset),
    .pc_query           (pc_query),
    .pc_jmp_feedback    (pc_jmp_feedback),
    .pc_jmp_take        (pc_jmp_take),
    .pc_stash_base      (pc_stash_base),
    .pc_jmp             (pc_jmp),
    .pc_prediction_take (pc_prediction_take),
    .perf_branches      (perf_branches),
    .perf_mispredicts   (perf_mispredicts),
    .last_target        (last_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer counters in 0..3, 64 entries, word-indexed PCs.
  int          m_cnt [64];
  int          m_br;
  int          m_mis;
  int          m_ghr;
  logic [31:0] m_last;

  function automatic int m_idx(input logic [31:0] pc);
    int h;
    h = 0;
`ifdef GSHARE_EN
    h = m_ghr;
`endif
    return (int'(pc >> 2) ^ h) & 63;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 2;
    m_br = 0; m_mis = 0; m_ghr = 0; m_last = 32'd0;
  endtask

  task automatic model_update(input logic t, input logic [31:0] s, input logic [31:0] j);
    int i;
    i = m_idx(s);
    m_br++;
    if ((m_cnt[i] >= 2) != t) m_mis++;
    if (t) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
    else   m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
    m_ghr  = ((m_ghr << 1) | int'(t)) & 63;
    m_last = j;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic t, input logic [31:0] s, input logic [31:0] q, input logic [31:0] j);
    pc_jmp_feedback = f; pc_jmp_take = t; pc_stash_base = s; pc_query = q; pc_jmp = j;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        fb;
    logic        take;
    logic [31:0] stash;
    logic [31:0] query;
    logic        exp_pred;
    int          exp_cnt;
    int          exp_br;
    int          exp_mis;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int qi;
    vectors = 0;
    miscompares = 0;

    // Directed rows: pred/cnt/perf are the values seen just before each row's clock edge.
    vecs[0]  = '{1'b1, 1'b0, 32'h40,  32'h40,  1'b1, 2, 0,  0};
    vecs[1]  = '{1'b1, 1'b0, 32'h40,  32'h40,  1'b0, 1, 1,  1};
    vecs[2]  = '{1'b1, 1'b0, 32'h40,  32'h40,  1'b0, 0, 2,  1};
    vecs[3]  = '{1'b0, 1'b0, 32'h40,  32'h40,  1'b0, 0, 3,  1};
    vecs[4]  = '{1'b1, 1'b0, 32'h40,  32'h40,  1'b0, 0, 3,  1};
    vecs[5]  = '{1'b0, 1'b0, 32'h40,  32'h40,  1'b0, 0, 4,  1};
    vecs[6]  = '{1'b1, 1'b1, 32'h40,  32'h40,  1'b0, 0, 4,  1};
    vecs[7]  = '{1'b0, 1'b0, 32'h40,  32'h40,  1'b0, 1, 5,  2};
    vecs[8]  = '{1'b1, 1'b1, 32'h40,  32'h40,  1'b0, 1, 5,  2};
    vecs[9]  = '{1'b0, 1'b0, 32'h40,  32'h40,  1'b1, 2, 6,  3};
    vecs[10] = '{1'b1, 1'b1, 32'h40,  32'h40,  1'b1, 2, 6,  3};
    vecs[11] = '{1'b1, 1'b1, 32'h40,  32'h40,  1'b1, 3, 7,  3};
    vecs[12] = '{1'b1, 1'b0, 32'h40,  32'h40,  1'b1, 3, 8,  3};
    vecs[13] = '{1'b0, 1'b0, 32'h40,  32'h40,  1'b1, 2, 9,  4};
    vecs[14] = '{1'b1, 1'b0, 32'h000, 32'h100, 1'b1, 2, 9,  4};
    vecs[15] = '{1'b1, 1'b0, 32'h000, 32'h100, 1'b0, 1, 10, 5};
    vecs[16] = '{1'b0, 1'b0, 32'h000, 32'h100, 1'b0, 0, 11, 5};
    vecs[17] = '{1'b0, 1'b0, 32'h000, 32'h004, 1'b1, 2, 11, 5};
    vecs[18] = '{1'b1, 1'b0, 32'h10,  32'h10,  1'b1, 2, 11, 5};
    vecs[19] = '{1'b1, 1'b1, 32'h10,  32'h10,  1'b0, 1, 12, 6};
    vecs[20] = '{1'b0, 1'b0, 32'h10,  32'h10,  1'b1, 2, 13, 7};

    // Reset with a feedback strobe pending: the strobe must be discarded.
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h40, 32'h0, 32'hDEAD_BEEF);
    repeat (2) begin
      @(negedge clk);
      pc_query = $urandom;
      #1;
      check("pred_in_reset", 32'(pc_prediction_take), 32'd1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h124, 32'h0);
    model_reset();
    @(negedge clk);
    check("pred_after_reset", 32'(pc_prediction_take), 32'd1);
    check("perf_br_reset", perf_branches, 32'd0);
    check("perf_mis_reset", perf_mispredicts, 32'd0);
    check("last_target_reset", last_target, 32'd0);
    step();

`ifndef GSHARE_EN
    for (int k = 0; k < 21; k++) begin
      drive(vecs[k].fb, vecs[k].take, vecs[k].stash, vecs[k].query, 32'hA000_0000 | 32'(k));
      @(negedge clk);
      qi = int'(vecs[k].query[7:2]);
      check($sformatf("pred_row%0d", k), 32'(pc_prediction_take), 32'(vecs[k].exp_pred));
      check($sformatf("cnt_row%0d", k), 32'(u_dut.u_table.mem[qi]), 32'(vecs[k].exp_cnt));
      check($sformatf("br_row%0d", k), perf_branches, 32'(vecs[k].exp_br));
      check($sformatf("mis_row%0d", k), perf_mispredicts, 32'(vecs[k].exp_mis));
      step();
    end
    check("last_target_table", last_target, 32'hA000_0013);
`endif

    // Reset mid-training with a taken strobe on an entry that would otherwise move.
    drive(1'b1, 1'b1, 32'h40, 32'h0, 32'h1234_5678);
    reset = 1'b0;
    @(negedge clk);
    check("pred_mid_reset", 32'(pc_prediction_take), 32'd1);
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("br_after_mid_reset", perf_branches, 32'd0);
    check("cnt_after_mid_reset", 32'(u_dut.u_table.mem[16]), 32'd2);
    check("last_after_mid_reset", last_target, 32'd0);
    step();

    // History sequence T, NT, T on PC 0x80, then one more taken update.
    drive(1'b1, 1'b1, 32'h80, 32'h0, 32'h0); step();
    drive(1'b1, 1'b0, 32'h80, 32'h0, 32'h0); step();
    drive(1'b1, 1'b1, 32'h80, 32'h0, 32'h0); step();
    drive(1'b0, 1'b0, 32'h80, 32'h0, 32'h0);
    @(negedge clk);
    check("br_hist_seq", perf_branches, 32'd3);
`ifdef GSHARE_EN
    check("ghr_101", 32'(u_dut.ghr[2:0]), 32'd5);
`endif
    step();
    drive(1'b1, 1'b1, 32'h80, 32'h0, 32'h0); step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
`ifdef GSHARE_EN
    check("cnt_idx25", 32'(u_dut.u_table.mem[37]), 32'd3);
`else
    check("cnt_idx25", 32'(u_dut.u_table.mem[37]), 32'd2);
    check("cnt_idx20", 32'(u_dut.u_table.mem[32]), 32'd3);
`endif
    step();

    // Randomized traffic against the model, with occasional resets racing feedback.
    do_reset(1);
    for (int n = 0; n < 600; n++) begin
      logic rst_now;
      logic [31:0] s;
      rst_now = (n % 150 == 149);
      s = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), s,
            ($urandom_range(0, 1) == 1) ? s : (($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)),
            $urandom);
      reset = !rst_now;
      @(negedge clk);
      if (rst_now) begin
        check("rnd_pred_reset", 32'(pc_prediction_take), 32'd1);
        model_reset();
      end else begin
        check("rnd_pred", 32'(pc_prediction_take), 32'(m_cnt[m_idx(pc_query)] >= 2));
        check("rnd_br", perf_branches, 32'(m_br));
        check("rnd_mis", perf_mispredicts, 32'(m_mis));
        check("rnd_last", last_target, m_last);
        if (pc_jmp_feedback) model_update(pc_jmp_take, pc_stash_base, pc_jmp);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_branch_prediction_bht.md
Name: if_branch_prediction_bht

Overview:
- Dynamic successor to the IF-stage static predictor; replaces the always-taken decision with a parametrised table of saturating counters.
- The table is indexed by PC bits (optionally hashed with global history).
- Sits in IF: queried combinationally with the fetch PC; trained by EX-stage resolution feedback.
- Keeps the feedback port names of the static predictor so EX wiring is unchanged; adds a query PC input and performance counters.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries by default).
- CNT_BITS, 2, width of each saturating counter; legal range 1..4.
- PC_LSB, 2, lowest PC bit used for indexing (word-aligned fetch).
- HIST_BITS, 6, global history length; used only with GSHARE_EN; must be <= INDEX_BITS.
- PERF_BITS, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_query  in  32  fetch PC to predict.
- pc_jmp_feedback  in  1  EX resolved a conditional branch this cycle (update strobe).
- pc_jmp_take  in  1  resolved outcome: 1 = taken; valid with pc_jmp_feedback.
- pc_stash_base  in  32  PC of the resolved branch; valid with pc_jmp_feedback.
- pc_jmp  in  32  resolved target; captured into last_target for debug, not used for prediction.
- pc_prediction_take  out  1  prediction for pc_query.
- perf_branches  out  PERF_BITS  count of feedback strobes.
- perf_mispredicts  out  PERF_BITS  count of feedback strobes where the table disagreed with the outcome.
- last_target  out  32  pc_jmp captured on the last feedback.

Behaviour:
- Reset is synchronous, active-low, and sampled on the rising edge of clk while reset == 0.
  - All counters go to weakly-taken: 1 << (CNT_BITS-1), e.g. 2'b10.
  - ghr, perf_branches, perf_mispredicts and last_target go to 0.
  - While reset == 0, pc_prediction_take = 1 (matches legacy static behaviour).
- Query path is combinational, zero latency.
  - q_idx = pc_query[PC_LSB+INDEX_BITS-1 : PC_LSB].
  - pc_prediction_take = MSB of table[q_idx].
- Update happens on the clock edge when reset == 1 and pc_jmp_feedback == 1.
  - u_idx is computed from pc_stash_base using the same rule as q_idx.
  - If pc_jmp_take == 1, table[u_idx] increments, saturating at 2^CNT_BITS - 1.
  - If pc_jmp_take == 0, table[u_idx] decrements, saturating at 0.
  - perf_branches increments.
  - perf_mispredicts increments if MSB(table[u_idx]) before the update differs from pc_jmp_take.
  - last_target <= pc_jmp.
- Perf counters wrap modulo 2^PERF_BITS; no sticky overflow.
- Same-cycle query and update of the same entry: the query returns the pre-update value. No write-through bypass.
- No update occurs when pc_jmp_feedback == 0. pc_jmp_take, pc_stash_base and pc_jmp are don't-care then.
- Reset asserted mid-training: reset wins over any simultaneous feedback; the update is discarded.
- Only one update per cycle. The table is register-based, not RAM: single write port plus one combinational read port (two for the mispredict compare).

Optional Feature:
- GSHARE_EN.
- Defined:
  - A HIST_BITS-bit global history register ghr is added.
  - Both indices become pc_bits XOR {zero-pad, ghr}.
  - On each feedback, ghr <= {ghr[HIST_BITS-2:0], pc_jmp_take}.
  - The update index uses ghr before the shift in that cycle.
  - The query in the same cycle uses the pre-shift ghr.
- Undefined:
  - ghr does not exist; pure bimodal indexing.
  - All other behaviour is identical.

Decomposition:
- Shared package bp_pkg holds:
  - counter-width default;
  - function sat_update(cnt, take) returning the saturated next value;
  - function bp_index(pc, ghr) implementing the index/hash rule.
- One natural sub-module: bp_sat_counter_table (register array, sync active-low reset to the init value, one write port, two combinational read ports).
- The top level holds ghr, the perf counters and the output muxing.

Test Plan:
- Reset check: hold reset = 0 for 2 cycles, then release.
  - During reset: pc_prediction_take = 1.
  - After release: any pc_query predicts 1; perf counters read 0.
- Saturation down: feed 3 not-taken for pc_stash_base = 0x40, then query pc_query = 0x40.
  - Prediction = 0; counter reads 0.
  - A 4th not-taken leaves the counter at 0, and perf_mispredicts = 1 in total.
- Saturation up and hysteresis: from strongly not-taken, feed 1 taken and query → 0; feed a 2nd taken and query → 1; 2 more taken saturate at 3; 1 not-taken still predicts 1.
- Aliasing (INDEX_BITS = 6, PC_LSB = 2): train 0x000 not-taken ×2.
  - Query 0x100 → 0 (same entry).
  - Query 0x004 → 1 (untouched entry).
- Same-cycle hazard: table[0x10] = 1 (weakly not-taken); query 0x10 and update 0x10 taken in the same cycle.
  - Output = 0 that cycle.
  - Output = 1 the next cycle.
- GSHARE_EN: feed taken, not-taken, taken on PC 0x80.
  - ghr = 3'b101 in the low bits.
  - The next update targets index 0x20 ^ 0x05 = 0x25 (checked via hierarchical peek).
  - Without the macro, index 0x20 is used and perf_branches = 3.
